// File: rtl/apb_master_bridge.sv
// rtl/apb_master_bridge.sv - single-outstanding APB4 initiator driven by a valid/ready command port
module apb_master_bridge #(
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_write,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [DATA_W-1:0]   cmd_wdata,
    input  logic [DATA_W/8-1:0] cmd_strb,

    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic                rsp_timeout,

    output logic                busy,

    output logic                psel,
    output logic                penable,
    output logic                pwrite,
    output logic [ADDR_W-1:0]   paddr,
    output logic [DATA_W-1:0]   pwdata,
    output logic [DATA_W/8-1:0] pstrb,
    input  logic                pready,
    input  logic [DATA_W-1:0]   prdata,
    input  logic                pslverr
);

    localparam int CNT_W = $clog2(TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS,
        S_RESP
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;

    assign cmd_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);

    // The APB output registers double as the latched command: they are loaded
    // once on accept and only cleared when the transfer leaves ACCESS.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            wait_cnt    <= '0;
            psel        <= 1'b0;
            penable     <= 1'b0;
            pwrite      <= 1'b0;
            paddr       <= '0;
            pwdata      <= '0;
            pstrb       <= '0;
            rsp_valid   <= 1'b0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
            rsp_rdata   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        if (cmd_addr[1:0] != 2'b00) begin
                            state       <= S_RESP;
                            rsp_valid   <= 1'b1;
                            rsp_err     <= 1'b1;
                            rsp_timeout <= 1'b0;
                            rsp_rdata   <= '0;
                        end else begin
                            state   <= S_SETUP;
                            psel    <= 1'b1;
                            penable <= 1'b0;
                            pwrite  <= cmd_write;
                            paddr   <= cmd_addr;
                            pwdata  <= cmd_write ? cmd_wdata : '0;
                            pstrb   <= cmd_write ? cmd_strb : '0;
                        end
                    end
                end

                S_SETUP: begin
                    state    <= S_ACCESS;
                    penable  <= 1'b1;
                    wait_cnt <= '0;
                end

                S_ACCESS: begin
                    // pready wins over the timeout check in the same cycle.
                    if (pready) begin
                        state       <= S_RESP;
                        rsp_valid   <= 1'b1;
                        rsp_err     <= pslverr;
                        rsp_timeout <= 1'b0;
                        rsp_rdata   <= (!pwrite && !pslverr) ? prdata : '0;
                        psel        <= 1'b0;
                        penable     <= 1'b0;
                        paddr       <= '0;
                        pwdata      <= '0;
                        pstrb       <= '0;
                    end else if (wait_cnt == CNT_LAST) begin
                        state       <= S_RESP;
                        rsp_valid   <= 1'b1;
                        rsp_err     <= 1'b1;
                        rsp_timeout <= 1'b1;
                        rsp_rdata   <= '0;
                        psel        <= 1'b0;
                        penable     <= 1'b0;
                        paddr       <= '0;
                        pwdata      <= '0;
                        pstrb       <= '0;
                    end else if (wait_cnt != CNT_MAX) begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end

                S_RESP: begin
                    if (rsp_ready) begin
                        state       <= S_IDLE;
                        rsp_valid   <= 1'b0;
                        rsp_err     <= 1'b0;
                        rsp_timeout <= 1'b0;
                        rsp_rdata   <= '0;
                        wait_cnt    <= '0;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
// tb/tb_apb_master_bridge.sv - scoreboard bench for apb_master_bridge
module tb_apb_master_bridge;

    localparam int AW = 12;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int TO = 16;

    logic          clk, rst;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic [SW-1:0] cmd_strb;
    logic          rsp_valid, rsp_ready, rsp_err, rsp_timeout;
    logic [DW-1:0] rsp_rdata;
    logic          busy;
    logic          psel, penable, pwrite, pready, pslverr;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata, prdata;
    logic [SW-1:0] pstrb;

    typedef struct packed {
        logic          err;
        logic          to;
        logic [DW-1:0] rdata;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    apb_master_bridge #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout), .busy(busy),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
        .pwdata(pwdata), .pstrb(pstrb), .pready(pready), .prdata(prdata),
        .pslverr(pslverr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Issues one command, plays a slave with `waits` wait states, and checks the
    // response against the scoreboard; timing observations are returned.
    task automatic xfer(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                        input logic [SW-1:0] st, input int waits, input logic serr,
                        input logic [DW-1:0] rd,
                        output int t_setup, output int t_access, output int t_rsp,
                        output int pen_cnt, output logic [AW-1:0] a_addr,
                        output logic [DW-1:0] a_wdata, output logic [SW-1:0] a_strb,
                        output logic a_write, output logic unstable);
        exp_t e, got;
        int   cyc;
        bit   accepted, done, mis, to;
        t_setup = -1; t_access = -1; t_rsp = -1; pen_cnt = 0; unstable = 0;
        a_addr = '0; a_wdata = '0; a_strb = '0; a_write = 1'b0;
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd; cmd_strb = st;
        pready = 1'b0; pslverr = 1'b0; prdata = 32'hDEAD_BEEF;
        accepted = 0;
        for (int i = 0; i < 20 && !accepted; i++) begin
            if (cmd_ready) accepted = 1;
            tick();
        end
        if (!accepted) begin
            n_tests++; n_fail++;
            $display("FAIL accept_wait cmd_ready never seen for addr=%h", addr);
            cmd_valid = 1'b0;
            return;
        end
        mis     = (addr[1:0] != 2'b00);
        to      = !mis && (waits >= TO);
        e.to    = to;
        e.err   = mis || to || serr;
        e.rdata = (!wr && !e.err) ? rd : '0;
        exp_q.push_back(e);
        cmd_valid = 1'b0; cmd_write = ~wr; cmd_addr = ~addr; cmd_wdata = ~wd; cmd_strb = ~st;
        done = 0;
        cyc  = 1;
        while (!done && cyc < TO + 20) begin
            if (rsp_valid) begin
                t_rsp = cyc;
                done  = 1;
            end else begin
                if (psel && !penable && t_setup < 0) t_setup = cyc;
                if (psel && penable) begin
                    if (t_access < 0) begin
                        t_access = cyc;
                        a_addr = paddr; a_wdata = pwdata; a_strb = pstrb; a_write = pwrite;
                    end else if (paddr !== a_addr || pwdata !== a_wdata ||
                                 pstrb !== a_strb || pwrite !== a_write) begin
                        unstable = 1;
                    end
                    pen_cnt++;
                    pready  = (pen_cnt > waits);
                    pslverr = pready ? serr : 1'b0;
                    prdata  = pready ? rd : 32'hDEAD_BEEF;
                end else begin
                    pready = 1'b0; pslverr = 1'b0;
                end
                tick();
                cyc++;
            end
        end
        pready = 1'b0; pslverr = 1'b0; prdata = '0;
        n_tests++;
        if (!done) begin
            n_fail++;
            $display("FAIL rsp_wait no rsp_valid for addr=%h", addr);
        end else if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty response with nothing expected");
        end else begin
            e   = exp_q.pop_front();
            got = '{rsp_err, rsp_timeout, rsp_rdata};
            if (got !== e) begin
                n_fail++;
                $display("FAIL rsp_fields addr=%h got err=%b to=%b rdata=%h exp err=%b to=%b rdata=%h",
                         addr, got.err, got.to, got.rdata, e.err, e.to, e.rdata);
            end
        end
        if (rsp_ready) tick();
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick(); tick();
        n_tests++;
        if ({psel, penable, pwrite, paddr, pwdata, pstrb} !== '0) begin
            n_fail++;
            $display("FAIL reset_apb got psel=%b pen=%b pwr=%b paddr=%h pwdata=%h pstrb=%h exp all 0",
                     psel, penable, pwrite, paddr, pwdata, pstrb);
        end
        n_tests++;
        if ({rsp_valid, rsp_err, rsp_timeout, rsp_rdata, busy} !== '0) begin
            n_fail++;
            $display("FAIL reset_rsp got valid=%b err=%b to=%b rdata=%h busy=%b exp all 0",
                     rsp_valid, rsp_err, rsp_timeout, rsp_rdata, busy);
        end
        rst = 1'b0;
        tick();
        n_tests++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release got cmd_ready=%b busy=%b exp 1 0", cmd_ready, busy);
        end
    endtask

    task automatic test_write_zero_wait;
        int ts, ta, tr, pc;
        logic [AW-1:0] aa; logic [DW-1:0] aw; logic [SW-1:0] as; logic ar, un;
        rsp_ready = 1'b1;
        xfer(1'b1, 12'h00C, 32'h1234_5678, 4'hF, 0, 1'b0, 32'hCAFE_F00D,
             ts, ta, tr, pc, aa, aw, as, ar, un);
        n_tests++;
        if ({ts, ta, tr, pc} !== {32'd1, 32'd2, 32'd3, 32'd1}) begin
            n_fail++;
            $display("FAIL wr_latency got setup=%0d access=%0d rsp=%0d pen=%0d exp 1 2 3 1", ts, ta, tr, pc);
        end
        n_tests++;
        if ({aa, aw, as, ar} !== {12'h00C, 32'h1234_5678, 4'hF, 1'b1}) begin
            n_fail++;
            $display("FAIL wr_apb got paddr=%h pwdata=%h pstrb=%h pwrite=%b exp 00c 12345678 f 1", aa, aw, as, ar);
        end
        n_tests++;
        if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_idle got cmd_ready=%b rsp_valid=%b busy=%b exp 1 0 0", cmd_ready, rsp_valid, busy);
        end
    endtask

    task automatic test_read_wait;
        int ts, ta, tr, pc;
        logic [AW-1:0] aa; logic [DW-1:0] aw; logic [SW-1:0] as; logic ar, un;
        xfer(1'b0, 12'h000, 32'h5555_5555, 4'hF, 2, 1'b0, 32'h0000_0100,
             ts, ta, tr, pc, aa, aw, as, ar, un);
        n_tests++;
        if ({pc, tr} !== {32'd3, 32'd5}) begin
            n_fail++;
            $display("FAIL rd_wait got pen=%0d rsp=%0d exp 3 5", pc, tr);
        end
        n_tests++;
        if ({aa, aw, as, ar, un} !== {12'h000, 32'h0, 4'h0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL rd_apb got paddr=%h pwdata=%h pstrb=%h pwrite=%b unstable=%b exp 000 0 0 0 0",
                     aa, aw, as, ar, un);
        end
    endtask

    task automatic test_slverr;
        int ts, ta, tr, pc;
        logic [AW-1:0] aa; logic [DW-1:0] aw; logic [SW-1:0] as; logic ar, un;
        xfer(1'b1, 12'h000, 32'hA5A5_A5A5, 4'hF, 1, 1'b1, 32'h0000_0077,
             ts, ta, tr, pc, aa, aw, as, ar, un);
        n_tests++;
        if (pc !== 2) begin
            n_fail++;
            $display("FAIL slverr_wr_pen got %0d exp 2", pc);
        end
        xfer(1'b0, 12'h008, 32'h0, 4'h0, 0, 1'b1, 32'hFFFF_FFFF,
             ts, ta, tr, pc, aa, aw, as, ar, un);
    endtask

    task automatic test_timeout;
        int ts, ta, tr, pc;
        logic [AW-1:0] aa; logic [DW-1:0] aw; logic [SW-1:0] as; logic ar, un;
        xfer(1'b0, 12'h01C, 32'h0, 4'h0, 1000, 1'b0, 32'h0000_1234,
             ts, ta, tr, pc, aa, aw, as, ar, un);
        n_tests++;
        if ({pc, tr} !== {32'd16, 32'd18}) begin
            n_fail++;
            $display("FAIL timeout_pen got pen=%0d rsp=%0d exp 16 18", pc, tr);
        end
        n_tests++;
        if (psel !== 1'b0 || penable !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_bus got psel=%b penable=%b exp 0 0", psel, penable);
        end
        xfer(1'b0, 12'h01C, 32'h0, 4'h0, 0, 1'b0, 32'h0000_00AB,
             ts, ta, tr, pc, aa, aw, as, ar, un);
        xfer(1'b0, 12'h014, 32'h0, 4'h0, TO - 1, 1'b0, 32'h0000_5A5A,
             ts, ta, tr, pc, aa, aw, as, ar, un);
        n_tests++;
        if (pc !== TO) begin
            n_fail++;
            $display("FAIL last_cycle_ready_pen got %0d exp %0d", pc, TO);
        end
    endtask

    task automatic test_back_to_back;
        int ts, ta, tr, pc;
        logic [AW-1:0] aa; logic [DW-1:0] aw; logic [SW-1:0] as; logic ar, un;
        logic [DW+1:0] snap;
        bit bad;
        rsp_ready = 1'b0;
        xfer(1'b0, 12'h010, 32'h0, 4'h0, 0, 1'b0, 32'h0BAD_CAFE,
             ts, ta, tr, pc, aa, aw, as, ar, un);
        snap = {rsp_err, rsp_timeout, rsp_rdata};
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 12'h006; cmd_wdata = '0; cmd_strb = '0;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (rsp_valid !== 1'b1 || cmd_ready !== 1'b0 || psel !== 1'b0 ||
                {rsp_err, rsp_timeout, rsp_rdata} !== snap) bad = 1;
        end
        n_tests++;
        if (bad) begin
            n_fail++;
            $display("FAIL hold_stable got valid=%b cmd_ready=%b err=%b rdata=%h exp 1 0 %b %h",
                     rsp_valid, cmd_ready, rsp_err, rsp_rdata, snap[DW+1], snap[DW-1:0]);
        end
        rsp_ready = 1'b1;
        tick();
        n_tests++;
        if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_release got cmd_ready=%b rsp_valid=%b busy=%b exp 1 0 0",
                     cmd_ready, rsp_valid, busy);
        end
        xfer(1'b0, 12'h006, 32'h0, 4'h0, 0, 1'b0, 32'h0000_0099,
             ts, ta, tr, pc, aa, aw, as, ar, un);
        n_tests++;
        if ({ts, ta, tr} !== {-32'sd1, -32'sd1, 32'sd1}) begin
            n_fail++;
            $display("FAIL misaligned got setup=%0d access=%0d rsp=%0d exp -1 -1 1", ts, ta, tr);
        end
    endtask

    task automatic test_reset_abort;
        int ts, ta, tr, pc;
        logic [AW-1:0] aa; logic [DW-1:0] aw; logic [SW-1:0] as; logic ar, un;
        bit stray;
        rsp_ready = 1'b1;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 12'h014; cmd_wdata = '0; cmd_strb = '0;
        pready = 1'b0;
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        n_tests++;
        if (psel !== 1'b1 || penable !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_in_access got psel=%b penable=%b exp 1 1", psel, penable);
        end
        rst = 1'b1;
        tick();
        n_tests++;
        if ({psel, penable, rsp_valid, busy} !== 4'b0000) begin
            n_fail++;
            $display("FAIL abort_reset got psel=%b pen=%b rsp_valid=%b busy=%b exp 0000",
                     psel, penable, rsp_valid, busy);
        end
        rst = 1'b0;
        stray = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (rsp_valid !== 1'b0) stray = 1;
        end
        n_tests++;
        if (stray) begin
            n_fail++;
            $display("FAIL abort_no_rsp got rsp_valid=1 exp 0");
        end
        xfer(1'b1, 12'h018, 32'hDEAD_0001, 4'h3, 0, 1'b0, 32'h0,
             ts, ta, tr, pc, aa, aw, as, ar, un);
        n_tests++;
        if ({tr, pc, aa, aw, as} !== {32'd3, 32'd1, 12'h018, 32'hDEAD_0001, 4'h3}) begin
            n_fail++;
            $display("FAIL after_abort got rsp=%0d pen=%0d paddr=%h pwdata=%h pstrb=%h exp 3 1 018 dead0001 3",
                     tr, pc, aa, aw, as);
        end
    endtask

    initial begin
        rst = 1'b1;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_strb = '0;
        rsp_ready = 1'b1; pready = 1'b0; prdata = '0; pslverr = 1'b0;
        test_reset();
        test_write_zero_wait();
        test_read_wait();
        test_slverr();
        test_timeout();
        test_back_to_back();
        test_reset_abort();
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_leftover got %0d entries exp 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
- Single-outstanding APB4 initiator that issues register transactions to the timer register block and any other APB slave in the subsystem.
- A simple command port (valid/ready) is converted into APB SETUP/ACCESS phases.
- Each completed transfer returns one response (read data, error, timeout) on a valid/ready response port.
- Used by the test/debug controller and the boot sequencer to program TCR, TDR0/1, TCMP0/1, TIER, TISR and THCSR.

Parameters:
- ADDR_W, 12, APB address width (timer map 0x00-0x1C).
- DATA_W, 32, APB data width; strobe width is DATA_W/8.
- TIMEOUT, 16, maximum ACCESS cycles with pready low before the transfer is aborted (legal range 2..65535).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  byte address.
- cmd_wdata  in  DATA_W  write data.
- cmd_strb  in  DATA_W/8  byte strobes (writes only).
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed when rsp_valid & rsp_ready.
- rsp_rdata  out  DATA_W  read data; 0 for writes, errors and timeouts.
- rsp_err  out  1  transfer failed (pslverr, timeout or misaligned).
- rsp_timeout  out  1  failure caused by timeout.
- busy  out  1  state != IDLE.
- psel  out  1  APB select.
- penable  out  1  APB enable.
- pwrite  out  1  APB direction.
- paddr  out  ADDR_W  APB address.
- pwdata  out  DATA_W  APB write data.
- pstrb  out  DATA_W/8  APB strobes.
- pready  in  1  slave ready.
- prdata  in  DATA_W  slave read data.
- pslverr  in  1  slave error.

Behaviour:
- Reset (rst=1 at a clock edge):
  - state = IDLE.
  - psel, penable, pwrite, paddr, pwdata, pstrb = 0.
  - rsp_valid, rsp_err, rsp_timeout, rsp_rdata = 0.
  - Wait counter = 0, busy = 0; cmd_ready = 1 after reset releases.
  - Reset in any state aborts the transfer immediately; no response is produced for it.
- FSM IDLE -> SETUP -> ACCESS -> RESP -> IDLE; all outputs are registered except cmd_ready and busy, which are decoded from state.
- IDLE:
  - cmd_ready=1; on accept, latch write/addr/wdata/strb.
  - If cmd_addr[1:0] != 0, go straight to RESP with rsp_err=1, rsp_timeout=0, and no APB activity.
  - Otherwise go to SETUP.
- SETUP (1 cycle):
  - psel=1, penable=0; paddr/pwrite/pwdata driven from latched values.
  - pstrb = latched strb for writes, 0 for reads.
  - pwdata = 0 for reads.
  - Next state is ACCESS.
- ACCESS:
  - psel=1, penable=1; all APB outputs held stable.
  - Wait counter increments each cycle with pready=0.
  - pready=1: capture prdata (reads only) and pslverr into the response regs, then go to RESP.
  - Counter == TIMEOUT-1 with pready=0: abort, go to RESP with rsp_err=1, rsp_timeout=1, rsp_rdata=0.
  - pready takes priority over timeout in the same cycle.
- RESP:
  - psel=penable=0; paddr/pwdata/pstrb return to 0.
  - rsp_valid=1 with rsp fields held stable until rsp_ready.
  - On handshake: clear rsp_valid and the counter, go to IDLE.
  - rsp_rdata=0 whenever rsp_err=1.
- Latency, zero-wait slave, rsp_ready=1:
  - Accept at edge N; SETUP visible cycle N+1; ACCESS N+2; rsp_valid N+3; IDLE/cmd_ready N+4.
- Back-to-back commands: minimum 4 cycles per transfer. A new command is never accepted while rsp_valid=1.
- cmd_* inputs are ignored outside IDLE; latched values are not affected by command changes mid-transfer.
- Wait counter width is ceil(log2(TIMEOUT))+1; it saturates and never wraps.

Test Plan:
- Write 0x0C (TCMP0), data 0x1234_5678, strb 0xF, pready tied 1 -> psel=1/penable=0 at N+1; penable=1 with paddr=0x0C, pwdata=0x12345678, pstrb=0xF at N+2; rsp_valid at N+3 with err=0, rdata=0.
- Read 0x00 (TCR), slave inserts 2 wait states then returns 0x0000_0100 -> penable held 3 cycles, pstrb=0, pwdata=0; rsp_rdata=0x100, err=0.
- Write 0x00 with slave pslverr=1 on the ready cycle -> rsp_err=1, rsp_timeout=0, rsp_rdata=0.
- TIMEOUT=16, pready stuck 0 on a read of 0x1C -> penable high exactly 16 cycles, then psel/penable=0; rsp_err=1, rsp_timeout=1, rdata=0. A following read with pready=1 succeeds.
- rsp_ready low for 5 cycles with a second cmd_valid pending -> rsp fields stable; cmd_ready=0 until the response handshake. Second command accepted the cycle after return to IDLE; misaligned addr 0x06 -> immediate error response, no psel pulse.
- rst=1 asserted during ACCESS -> next cycle psel=penable=rsp_valid=0, busy=0; no response for the aborted transfer; a new command completes normally.
